// File: rtl/tc_timer_pkg.sv
// Shared constants for the tc_timer peripheral: register offsets,
// CTRL field positions, mode encodings and FSM state encodings.
package tc_timer_pkg;

  // Word offsets decoded from addr[3:2]
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE field encodings; 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] TC_MODE_ONESHOT = 2'd0;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Assemble the CTRL read value from its stored fields
  function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode,
                                            input logic im);
    ctrl_word = {28'd0, im, mode, en};
  endfunction

endpackage

// File: rtl/tc_timer.sv
// tc_timer: bus-programmable 32-bit down-counting timer with interrupt.
// Optional build macro TC_MODE1_EN enables the auto-reload mode; without it
// the MODE field is not stored, reads as 0, and every expiry is one-shot.
module tc_timer
  import tc_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic        ctrl_en_q, ctrl_im_q;
  logic [1:0]  ctrl_mode_q;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        irq_pending_q, irq_pending_d;
  logic        en_clear;
  logic        auto_reload;
  logic        wr_ctrl, wr_preset;
  logic        unused_bits;

  assign wr_ctrl   = we && (addr[3:2] == TC_CTRL);
  assign wr_preset = we && (addr[3:2] == TC_PRESET);

`ifdef TC_MODE1_EN
  // MODE field storage; only value 1 selects auto-reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_mode_q <= TC_MODE_ONESHOT;
    end else if (wr_ctrl) begin
      ctrl_mode_q <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
    end
  end
  assign auto_reload = (ctrl_mode_q == TC_MODE_RELOAD);
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:4]};
`else
  assign ctrl_mode_q = TC_MODE_ONESHOT;
  assign auto_reload = 1'b0;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:4],
                         wdata[CTRL_MODE_HI:CTRL_MODE_LO]};
`endif

  // CTRL EN/IM storage; a bus write outranks the FSM clearing EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en_q <= 1'b0;
      ctrl_im_q <= 1'b0;
    end else if (wr_ctrl) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      ctrl_en_q <= wdata[CTRL_EN];
      ctrl_im_q <= wdata[CTRL_IM];
    end else if (en_clear) begin
      ctrl_en_q <= 1'b0;
    end
  end

  // PRESET storage; only consumed by the next LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset_q <= 32'd0;
    end else if (wr_preset) begin
      preset_q <= wdata;
    end
  end

  // Next-state, next-count and pending-flag logic
  always_comb begin
    // NOTE: assigning every output a default first prevents latch inference.
    state_d       = state_q;
    count_d       = count_q;
    irq_pending_d = irq_pending_q;
    en_clear      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // COUNT of 0 or 1 both expire here, so PRESET=0 times like PRESET=1
          count_d       = 32'd0;
          irq_pending_d = 1'b1;
          state_d       = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (auto_reload) irq_pending_d = 1'b0;
        else             en_clear      = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Software acknowledges by writing CTRL or PRESET
    if (wr_ctrl || wr_preset) irq_pending_d = 1'b0;
  end

  // FSM, COUNT and pending-flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      count_q       <= 32'd0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  // Zero-latency register read; reserved offset returns 0
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      TC_CTRL:   rdata = ctrl_word(ctrl_en_q, ctrl_mode_q, ctrl_im_q);
      TC_PRESET: rdata = preset_q;
      TC_COUNT:  rdata = count_q;
      default:   rdata = 32'd0;
    endcase
  end

  assign irq = irq_pending_q & ctrl_im_q;

endmodule

// File: tb/tb_tc_timer.sv
// Directed self-checking bench for tc_timer. Expected values are
// hand-derived from the register map and FSM timing.
module tb_tc_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_PRESET = 32'h4;
  localparam logic [31:0] A_COUNT  = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle write; the sampling edge is the next rising edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    step(3);
    reset = 1'b1;
    step(1);
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h want %h", d, 32'd0); end
    bus_read(A_PRESET, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_preset got %h want %h", d, 32'd0); end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_count got %h want %h", d, 32'd0); end
    bus_read(A_RSVD, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rsvd got %h want %h", d, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'h9);            // edge E0
    step(2);                             // E0+2
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL oneshot_load got %0d want 5", d); end
    step(4);                             // E0+6
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL oneshot_count1 got %0d want 1", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_early got %b want 0", irq); end
    step(1);                             // E0+7
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_rise got %b want 1", irq); end
    step(1);                             // E0+8
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL oneshot_en_clear got %h want %h", d, 32'h8); end
    step(3);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold got %b want 1", irq); end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oneshot_count0 got %0d want 0", d); end
    bus_write(A_CTRL, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_ack got %b want 0", irq); end
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    logic        exp;
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'hB);            // edge E0
    bus_read(A_CTRL, d);
`ifdef TC_MODE1_EN
    checks++; if (d !== 32'hB) begin errors++; $display("FAIL periodic_ctrl got %h want %h", d, 32'hB); end
`else
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL periodic_ctrl got %h want %h", d, 32'h9); end
`endif
    for (int k = 1; k <= 22; k++) begin
      step(1);                           // E0+k
`ifdef TC_MODE1_EN
      exp = (k >= 4) && (((k - 4) % 5) == 0);
`else
      exp = (k >= 4);
`endif
      checks++;
      if (irq !== exp) begin
        errors++;
        $display("FAIL periodic_irq cycle %0d got %b want %b", k, irq, exp);
      end
    end
    bus_write(A_CTRL, 32'h0);
    step(4);
  endtask

  task automatic test_preset_zero;
    logic [31:0] d;
    bus_write(A_PRESET, 32'd0);
    bus_write(A_CTRL, 32'h1);            // edge E0, IM=0
    step(3);                             // E0+3: pending set but masked
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pz_masked got %b want 0", irq); end
    step(1);                             // E0+4: one-shot expiry cleared EN
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL pz_en_clear got %h want %h", d, 32'h0); end
    bus_write(A_CTRL, 32'h9);            // edge W: clears pending, restarts
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pz_ack got %b want 0", irq); end
    step(2);                             // W+2
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pz_irq_early got %b want 0", irq); end
    step(1);                             // W+3
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pz_irq_rise got %b want 1", irq); end
    bus_write(A_CTRL, 32'h0);
    step(2);
  endtask

  task automatic test_disable;
    logic [31:0] d;
    bus_write(A_PRESET, 32'd100);
    bus_write(A_CTRL, 32'h1);            // edge E0
    step(41);                            // E0+41: COUNT = 100 - 39
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd61) begin errors++; $display("FAIL dis_count61 got %0d want 61", d); end
    bus_write(A_CTRL, 32'h0);            // edge E0+42: last decrement
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd60) begin errors++; $display("FAIL dis_count60 got %0d want 60", d); end
    step(5);
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd60) begin errors++; $display("FAIL dis_hold got %0d want 60", d); end
    bus_write(A_COUNT, 32'hDEAD_BEEF);
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd60) begin errors++; $display("FAIL dis_count_ro got %0d want 60", d); end
    bus_write(A_CTRL, 32'h1);            // edge E1
    step(2);
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd100) begin errors++; $display("FAIL dis_reload got %0d want 100", d); end
    step(1);
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd99) begin errors++; $display("FAIL dis_resume got %0d want 99", d); end
    bus_write(A_CTRL, 32'h0);
    step(2);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bus_write(A_PRESET, 32'd50);
    bus_write(A_CTRL, 32'h9);            // edge E0
    step(10);                            // E0+10: COUNT = 50 - 8
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd42) begin errors++; $display("FAIL ar_precount got %0d want 42", d); end
    @(negedge clk);
    #1;
    reset = 1'b0;                        // between edges, no clock edge follows before reads
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL ar_ctrl got %h want %h", d, 32'd0); end
    bus_read(A_PRESET, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL ar_preset got %h want %h", d, 32'd0); end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL ar_count got %h want %h", d, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq got %b want 0", irq); end
    step(2);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    bus_write(A_COUNT, 32'd5);
    step(2);
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL ar_count_ro got %0d want 0", d); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_preset_zero();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
